// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM time-slot arbiter.
// Slot selection is written for up to MAX_CLIENTS clients.
package sram_arb_pkg;

    localparam int MAX_CLIENTS = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SLOT,
        ARB_GAP
    } arb_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } next_sel_t;

    // Index width that stays legal for a single client.
    function automatic int cli_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest enabled client strictly above cur; cur = -1 starts a frame.
    function automatic next_sel_t next_enabled(input logic [MAX_CLIENTS-1:0] mask, input int cur);
        next_sel_t sel;
        sel = '0;
        for (int i = MAX_CLIENTS - 1; i >= 0; i--) begin
            if (mask[i] && i > cur) begin
                sel.valid = 1'b1;
                sel.idx   = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sram_slot_arbiter_if.sv
// Client-side and SRAM-side signals of the slot arbiter.
// The slave modport is the arbiter; the master modport is the client/frame driver.
interface sram_slot_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
);
    logic                          i_start;
    logic [NUM_CLIENTS-1:0]        i_cli_en;
    logic [NUM_CLIENTS*ADDR_W-1:0] i_cli_addr;
    logic [NUM_CLIENTS-1:0]        i_cli_we_n;
    logic [NUM_CLIENTS*DATA_W-1:0] i_cli_wdata;
    logic [NUM_CLIENTS-1:0]        i_cli_done;

    logic [NUM_CLIENTS-1:0]        o_grant;
    logic [ADDR_W-1:0]             o_sram_addr;
    logic                          o_sram_we_n;
    logic [DATA_W-1:0]             o_sram_wdata;
    logic                          o_sram_dq_oe;
    logic                          o_busy;
    logic                          o_frame_done;
    logic                          o_overrun;
    logic                          o_timeout;

    modport slave (
        input  i_start, i_cli_en, i_cli_addr, i_cli_we_n, i_cli_wdata, i_cli_done,
        output o_grant, o_sram_addr, o_sram_we_n, o_sram_wdata, o_sram_dq_oe,
        output o_busy, o_frame_done, o_overrun, o_timeout
    );

    modport master (
        output i_start, i_cli_en, i_cli_addr, i_cli_we_n, i_cli_wdata, i_cli_done,
        input  o_grant, o_sram_addr, o_sram_we_n, o_sram_wdata, o_sram_dq_oe,
        input  o_busy, o_frame_done, o_overrun, o_timeout
    );

endinterface

// File: rtl/sram_arb_mux.sv
// One-hot grant to SRAM address/we_n/wdata mux.
// With no grant the bus is parked: address 0, write disabled, data 0.
module sram_arb_mux #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic [NUM_CLIENTS-1:0]        grant,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS-1:0]        cli_we_n,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
    output logic [ADDR_W-1:0]             addr,
    output logic                          we_n,
    output logic [DATA_W-1:0]             wdata
);

    always_comb begin
        addr  = '0;
        we_n  = 1'b1;
        wdata = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (grant[k]) begin
                addr  = addr  | cli_addr[k*ADDR_W +: ADDR_W];
                wdata = wdata | cli_wdata[k*DATA_W +: DATA_W];
                we_n  = cli_we_n[k];
            end
        end
    end

endmodule

// File: rtl/sram_slot_arbiter.sv
// Per-sample time-slot arbiter for the shared single-port audio SRAM.
// Define SRAM_ARB_TIMEOUT_EN to force a handover after TIMEOUT_CYCLES slot cycles.
module sram_slot_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 24
) (
    input logic               i_clk,
    input logic               i_rst_n,
    sram_slot_arbiter_if.slave bus
);

    localparam int CLI_IDX_W = cli_idx_w(NUM_CLIENTS);

    arb_state_e             state_q, state_d;
    logic [CLI_IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CLIENTS-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
    logic                   frame_done_q, frame_done_d;

    logic [NUM_CLIENTS-1:0] grant;
    logic [ADDR_W-1:0]      mux_addr;
    logic                   mux_we_n;
    logic [DATA_W-1:0]      mux_wdata;
    logic                   done_hit;
    logic                   timeout_hit;
    logic                   busy;
    next_sel_t              sel;

    assign grant    = (state_q == ARB_SLOT) ? (NUM_CLIENTS'(1) << idx_q) : '0;
    assign done_hit = |(bus.i_cli_done & grant);
    assign busy     = (state_q != ARB_IDLE);

    sram_arb_mux #(
        .NUM_CLIENTS(NUM_CLIENTS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_mux (
        .grant    (grant),
        .cli_addr (bus.i_cli_addr),
        .cli_we_n (bus.i_cli_we_n),
        .cli_wdata(bus.i_cli_wdata),
        .addr     (mux_addr),
        .we_n     (mux_we_n),
        .wdata    (mux_wdata)
    );

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] slot_cnt_q, slot_cnt_d;

    // Counting only inside SLOT means every slot entry starts from zero.
    assign slot_cnt_d  = (state_q == ARB_SLOT) ? slot_cnt_q + TO_W'(1) : '0;
    assign timeout_hit = (state_q == ARB_SLOT) && !done_hit &&
                         (slot_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) slot_cnt_q <= '0;
        else          slot_cnt_q <= slot_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        last_addr_d  = last_addr_q;
        frame_done_d = 1'b0;
        sel          = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.i_start) begin
                    mask_d = bus.i_cli_en;
                    sel    = next_enabled(MAX_CLIENTS'(bus.i_cli_en), -1);
                    if (sel.valid) begin
                        state_d = ARB_SLOT;
                        idx_d   = CLI_IDX_W'(sel.idx);
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            ARB_SLOT: begin
                last_addr_d = mux_addr;
                if (done_hit || timeout_hit) state_d = ARB_GAP;
            end
            ARB_GAP: begin
                sel = next_enabled(MAX_CLIENTS'(mask_q), int'(idx_q));
                if (sel.valid) begin
                    state_d = ARB_SLOT;
                    idx_d   = CLI_IDX_W'(sel.idx);
                end else begin
                    state_d      = ARB_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            state_q      <= ARB_IDLE;
            idx_q        <= '0;
            mask_q       <= '0;
            last_addr_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            last_addr_q  <= last_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The mux parks we_n high without a grant, which write-protects the SRAM outside SLOT.
    assign bus.o_grant      = grant;
    assign bus.o_sram_addr  = (state_q == ARB_SLOT) ? mux_addr : last_addr_q;
    assign bus.o_sram_we_n  = mux_we_n;
    assign bus.o_sram_wdata = mux_wdata;
    assign bus.o_sram_dq_oe = ~mux_we_n;
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_overrun    = bus.i_start && busy;
    assign bus.o_timeout    = timeout_hit;

endmodule
